// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - read-side output stage: FIFO read strobe, 1-cycle latency absorption, 2-entry valid/ready buffer
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 41,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  fifo_empty,
  output logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [1:0]            buf_count,
  output logic [CNT_WIDTH-1:0]  word_cnt
);

  logic [DATA_WIDTH-1:0] r_buf [2];
  logic                  r_head;
  logic [1:0]            r_count;
  logic                  r_inflight;
  logic [CNT_WIDTH-1:0]  r_word_cnt;

  logic                  w_pop;
  logic [2:0]            w_occ_next;
  logic                  w_tail;

  assign w_pop      = m_valid & m_ready;
  assign w_occ_next = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};

  // Only issue a read when the word landing next cycle is guaranteed a free slot.
  assign rd_en = ~rd_rst & ~fifo_empty & (w_occ_next < 3'd2);

  // Tail slot is head+count; identical to post-pop head + count - pop.
  assign w_tail = r_head ^ r_count[0];

  assign m_valid   = (r_count != 2'd0);
  assign m_data    = r_buf[r_head];
  assign buf_count = r_count;
  assign word_cnt  = r_word_cnt;

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      r_buf[0]   <= '0;
      r_buf[1]   <= '0;
      r_head     <= 1'b0;
      r_count    <= 2'd0;
      r_inflight <= 1'b0;
      r_word_cnt <= '0;
    end else begin
      r_inflight <= rd_en;
      if (r_inflight) begin
        r_buf[w_tail] <= rd_data;
      end
      if (w_pop) begin
        r_head     <= ~r_head;
        r_word_cnt <= r_word_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
      r_count <= w_occ_next[1:0];
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - scoreboard bench for fifo_rd_stream with a queue-based FIFO source model
module tb_fifo_rd_stream;

  localparam int DW = 41;
  localparam int CW = 4;

  logic          rd_clk = 1'b0;
  logic          rd_rst = 1'b1;
  logic          fifo_empty = 1'b1;
  logic          rd_en;
  logic [DW-1:0] rd_data = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic [1:0]    buf_count;
  logic [CW-1:0] word_cnt;

  fifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .rd_clk     (rd_clk),
    .rd_rst     (rd_rst),
    .fifo_empty (fifo_empty),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .buf_count  (buf_count),
    .word_cnt   (word_cnt)
  );

  always #5 rd_clk = ~rd_clk;

  logic [DW-1:0] src   [$];
  logic [DW-1:0] exp_q [$];
  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  bit            rst_req = 1'b1;
  int            ready_pct = 0;
  int            empty_pct = 0;
  logic [DW-1:0] pending = '0;
  bit            pending_v = 1'b0;
  bit            rd_seen = 1'b0;
  int            rd_cnt = 0;
  int            first_rd = -1;
  int            last_rd = -1;
  int            n_deliv = 0;
  int            first_hs = -1;
  int            last_hs = -1;
  int            model_cnt = 0;
  bit            want_first = 1'b0;
  logic [DW-1:0] first_after = '0;
  bit            prev_hold = 1'b0;
  logic [DW-1:0] prev_data = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // One read-clock cycle: drive inputs at negedge, then act as FIFO memory and read pointer.
  task automatic cycle();
    logic [63:0] g;
    @(negedge rd_clk);
    cyc++;
    g = {$urandom, $urandom};
    rd_rst     = rst_req;
    rd_data    = pending_v ? pending : g[DW-1:0];
    pending_v  = 1'b0;
    m_ready    = ($urandom_range(99) < ready_pct);
    fifo_empty = (src.size() == 0) || ($urandom_range(99) < empty_pct);
    #1;
    rd_seen = rd_en;
    if (rd_rst) begin
      check("rd_en_in_reset", rd_en, 0);
      exp_q.delete();
      model_cnt = 0;
    end else if (rd_en) begin
      check("rd_en_while_empty", fifo_empty, 0);
      if (src.size() > 0) begin
        pending   = src.pop_front();
        pending_v = 1'b1;
        exp_q.push_back(pending);
      end
      rd_cnt++;
      if (first_rd < 0) first_rd = cyc;
      last_rd = cyc;
    end
  endtask

  always @(negedge rd_clk) begin
    #2;
    if (!rd_rst) begin
      check("buf_count_le2", buf_count > 2'd2, 0);
      if (prev_hold) begin
        check("hold_valid", m_valid, 1);
        check("hold_data", m_data, prev_data);
      end
      if (m_valid && m_ready) begin
        check("scoreboard_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("m_data_order", m_data, exp_q.pop_front());
        check("word_cnt_track", word_cnt, model_cnt % (1 << CW));
        model_cnt++;
        n_deliv++;
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        if (want_first) begin
          first_after = m_data;
          want_first  = 1'b0;
        end
      end
    end
    prev_hold = !rd_rst && m_valid && !m_ready;
    prev_data = m_data;
  end

  initial begin
    int base;
    int k;
    logic [63:0] r;
    logic [DW-1:0] next_word;

    // Reset held with words available
    src = '{41'h1AA, 41'h1AB, 41'h1AC};
    rst_req = 1'b1;
    repeat (2) cycle();
    check("reset_m_valid", m_valid, 0);
    check("reset_buf_count", buf_count, 0);
    check("reset_word_cnt", word_cnt, 0);
    src.delete();
    rst_req = 1'b0;

    // Streaming 8 words with m_ready=1
    for (int i = 1; i <= 8; i++) src.push_back(DW'(i));
    ready_pct = 100; empty_pct = 0;
    rd_cnt = 0; first_rd = -1; first_hs = -1; base = n_deliv;
    repeat (16) cycle();
    check("stream_rd_cnt", rd_cnt, 8);
    check("stream_rd_consecutive", last_rd - first_rd, 7);
    check("stream_latency", first_hs - first_rd, 2);
    check("stream_hs_consecutive", last_hs - first_hs, 7);
    check("stream_delivered", n_deliv - base, 8);
    check("stream_word_cnt", word_cnt, 8);

    // Backpressure: 5 words, consumer stalled
    for (int i = 0; i < 5; i++) src.push_back(DW'(41'h100 + i));
    ready_pct = 0; rd_cnt = 0;
    repeat (10) cycle();
    check("bp_rd_pulses", rd_cnt, 2);
    check("bp_buf_count", buf_count, 2);
    check("bp_m_valid", m_valid, 1);
    check("bp_m_data", m_data, 41'h100);
    ready_pct = 100; base = n_deliv;
    repeat (12) cycle();
    check("bp_delivered", n_deliv - base, 5);
    check("bp_drained", exp_q.size(), 0);

    // Random backpressure and empty toggling over 1000 words
    for (int i = 0; i < 1000; i++) begin
      r = {$urandom, $urandom};
      src.push_back(r[DW-1:0]);
    end
    ready_pct = 50; empty_pct = 30; base = n_deliv; k = 0;
    while ((n_deliv - base) < 1000 && k < 20000) begin
      cycle();
      k++;
    end
    check("rand_delivered", n_deliv - base, 1000);
    check("rand_word_cnt", word_cnt, model_cnt % (1 << CW));
    check("rand_drained", exp_q.size(), 0);

    // Reset the cycle after a read strobe
    ready_pct = 0; empty_pct = 0;
    for (int i = 0; i < 6; i++) src.push_back(DW'(41'h200 + i));
    k = 0;
    do begin
      cycle();
      k++;
    end while (!rd_seen && k < 50);
    check("mid_rd_seen", rd_seen, 1);
    rst_req = 1'b1;
    cycle();
    rst_req = 1'b0;
    next_word = src[0];
    want_first = 1'b1;
    ready_pct = 100;
    cycle();
    check("mid_m_valid", m_valid, 0);
    check("mid_buf_count", buf_count, 0);
    check("mid_word_cnt", word_cnt, 0);
    repeat (12) cycle();
    check("mid_first_word", first_after, next_word);
    check("mid_first_seen", want_first, 0);

    // Counter wrap: 17 deliveries with a 4-bit counter
    rst_req = 1'b1;
    cycle();
    rst_req = 1'b0;
    src.delete();
    for (int i = 0; i < 17; i++) src.push_back(DW'(41'h300 + i));
    base = n_deliv;
    repeat (30) cycle();
    check("wrap_delivered", n_deliv - base, 17);
    check("wrap_word_cnt", word_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
